// File: rtl/frontend_ctrl_pkg.sv
// Shared types for the front-end redirect/flush controller.
//   fe_state_e : controller state (RUN, FLUSH, REFILL)
//   redirect_t : a redirect request (valid + target PC); the PC field is sized
//                for the widest supported XLEN and zero-extended from the real
//                PC width by the users of the type.
package frontend_ctrl_pkg;

    localparam int XLEN_MAX    = 64;
    localparam int FLUSH_CNT_W = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        REFILL = 2'd2
    } fe_state_e;

    typedef struct packed {
        logic                valid;
        logic [XLEN_MAX-1:0] pc;
    } redirect_t;

    function automatic redirect_t make_redirect(input logic [XLEN_MAX-1:0] pc);
        redirect_t r;
        r.valid = 1'b1;
        r.pc    = pc;
        return r;
    endfunction

endpackage

// File: rtl/frontend_ctrl_sat_counter.sv
// Saturating up-counter used for the front-end statistics.
// Ports:
//   clk   : clock
//   rst_n : async active-low reset, clears the count
//   inc   : add one this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/frontend_ctrl.sv
// Front-end redirect / flush controller.
// Arbitrates execute-stage mispredicts (lane 0 older, wins) against decode
// early redirects, drives the fetch redirect pulse, holds ext_flush for
// FLUSH_CYCLES cycles per mispredict followed by one REFILL cycle, and stalls
// fetch/decode when the backend dispatch queue is nearly full.
// Ports:
//   clk, reset (async, active low)
//   br_valid/br_mispredict/br_target : per-lane execute branch resolution
//   dec_redirect_valid/target        : decode-stage early redirect
//   be_free_slots                    : backend dispatch queue free entries
//   ext_stall, ext_flush             : fetch/decode control (registered)
//   redirect_valid, redirect_pc      : one-cycle fetch redirect (registered)
//   mispredict_cnt, stall_cnt        : saturating statistics
//
// state  | meaning
// RUN    | normal fetch; decode redirects accepted
// FLUSH  | ext_flush held, counting down remaining flush cycles
// REFILL | one quiet cycle after the flush before returning to RUN
module frontend_ctrl
    import frontend_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int QCNT_W       = 4,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            br_valid,
    input  logic [1:0]            br_mispredict,
    input  logic [1:0][XLEN-1:0]  br_target,
    input  logic                  dec_redirect_valid,
    input  logic [XLEN-1:0]       dec_redirect_target,
    input  logic [QCNT_W-1:0]     be_free_slots,
    output logic                  ext_stall,
    output logic                  ext_flush,
    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_pc,
    output logic [CNT_W-1:0]      mispredict_cnt,
    output logic [CNT_W-1:0]      stall_cnt
);

    logic [1:0]       exe_mp;
    logic             exe_any;
    logic [XLEN-1:0]  exe_target;

    fe_state_e                state_q, state_d;
    logic [FLUSH_CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic                     ext_flush_q, ext_flush_d;
    logic                     ext_stall_q, ext_stall_d;
    redirect_t                redir_q, redir_d;

    assign exe_mp     = br_valid & br_mispredict;
    assign exe_any    = |exe_mp;
    // Lane 0 is older, so it owns the redirect when both lanes mispredict.
    assign exe_target = exe_mp[0] ? br_target[0] : br_target[1];

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        ext_flush_d   = 1'b0;
        redir_d.valid = 1'b0;
        redir_d.pc    = redir_q.pc;

        if (exe_any) begin
            // A mispredict in any state (re)starts the flush sequence.
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
            ext_flush_d = 1'b1;
            redir_d     = make_redirect(XLEN_MAX'(exe_target));
        end else begin
            unique case (state_q)
                RUN: begin
                    if (dec_redirect_valid) begin
                        redir_d = make_redirect(XLEN_MAX'(dec_redirect_target));
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        state_d = REFILL;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
                        ext_flush_d = 1'b1;
                    end
                end
                REFILL: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        // Only RUN can stall, and RUN never flushes, so stall and flush are
        // mutually exclusive by construction.
        ext_stall_d = (state_d == RUN) && (be_free_slots <= QCNT_W'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            ext_flush_q <= 1'b0;
            ext_stall_q <= 1'b0;
            redir_q     <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            ext_flush_q <= ext_flush_d;
            ext_stall_q <= ext_stall_d;
            redir_q     <= redir_d;
        end
    end

    // Upper PC bits of the shared redirect type are always zero here.
    if (XLEN < XLEN_MAX) begin : g_pc_pad
        logic unused_pc_hi;
        assign unused_pc_hi = ^redir_q.pc[XLEN_MAX-1:XLEN];
    end

    sat_counter #(.WIDTH(CNT_W)) u_mispredict_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (exe_any),
        .count (mispredict_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (ext_stall_q),
        .count (stall_cnt)
    );

    assign ext_stall      = ext_stall_q;
    assign ext_flush      = ext_flush_q;
    assign redirect_valid = redir_q.valid;
    assign redirect_pc    = redir_q.pc[XLEN-1:0];

endmodule

// File: tb/tb_frontend_ctrl.sv
module tb_frontend_ctrl;

    logic             clk;
    logic             reset;
    logic [1:0]       br_valid;
    logic [1:0]       br_mispredict;
    logic [1:0][31:0] br_target;
    logic             dec_redirect_valid;
    logic [31:0]      dec_redirect_target;
    logic [3:0]       be_free_slots;
    logic             ext_stall;
    logic             ext_flush;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic [3:0]       mispredict_cnt;
    logic [3:0]       stall_cnt;

    int vectors;
    int miscompares;

    frontend_ctrl #(
        .XLEN(32), .FLUSH_CYCLES(2), .QCNT_W(4), .CNT_W(4)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .br_valid            (br_valid),
        .br_mispredict       (br_mispredict),
        .br_target           (br_target),
        .dec_redirect_valid  (dec_redirect_valid),
        .dec_redirect_target (dec_redirect_target),
        .be_free_slots       (be_free_slots),
        .ext_stall           (ext_stall),
        .ext_flush           (ext_flush),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .mispredict_cnt      (mispredict_cnt),
        .stall_cnt           (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        br_valid            = 2'b00;
        br_mispredict       = 2'b00;
        br_target[0]        = 32'h0;
        br_target[1]        = 32'h0;
        dec_redirect_valid  = 1'b0;
        dec_redirect_target = 32'h0;
        be_free_slots       = 4'd8;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_inputs();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        #3;
        vectors++; if (ext_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", ext_stall); end
        vectors++; if (ext_flush !== 1'b0) begin miscompares++; $display("FAIL reset_flush: got %b want 0", ext_flush); end
        vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rv: got %b want 0", redirect_valid); end
        vectors++; if (redirect_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0", redirect_pc); end
        vectors++; if (mispredict_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_mpcnt: got %0d want 0", mispredict_cnt); end
        vectors++; if (stall_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_stcnt: got %0d want 0", stall_cnt); end
        tick();
        reset = 1'b1;
        tick();
        vectors++; if (redirect_valid !== 1'b0 || ext_flush !== 1'b0) begin miscompares++; $display("FAIL reset_release: got rv=%b fl=%b want 0/0", redirect_valid, ext_flush); end
    endtask

    task automatic test_lane1_mispredict();
        apply_reset();
        br_valid = 2'b10; br_mispredict = 2'b10; br_target[1] = 32'h0000_0400;
        tick();
        clear_inputs();
        vectors++; if (redirect_valid !== 1'b1) begin miscompares++; $display("FAIL lane1_rv: got %b want 1", redirect_valid); end
        vectors++; if (redirect_pc !== 32'h400) begin miscompares++; $display("FAIL lane1_pc: got %h want 00000400", redirect_pc); end
        vectors++; if (ext_flush !== 1'b1) begin miscompares++; $display("FAIL lane1_flush1: got %b want 1", ext_flush); end
        vectors++; if (mispredict_cnt !== 4'd1) begin miscompares++; $display("FAIL lane1_mpcnt: got %0d want 1", mispredict_cnt); end
        tick();
        vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("FAIL lane1_rv_pulse: got %b want 0", redirect_valid); end
        vectors++; if (ext_flush !== 1'b1) begin miscompares++; $display("FAIL lane1_flush2: got %b want 1", ext_flush); end
        vectors++; if (redirect_pc !== 32'h400) begin miscompares++; $display("FAIL lane1_pc_hold: got %h want 00000400", redirect_pc); end
        tick();
        vectors++; if (ext_flush !== 1'b0 || ext_stall !== 1'b0) begin miscompares++; $display("FAIL lane1_refill: got fl=%b st=%b want 0/0", ext_flush, ext_stall); end
        tick();
        dec_redirect_valid = 1'b1; dec_redirect_target = 32'h0000_0500;
        tick();
        clear_inputs();
        vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h500 || ext_flush !== 1'b0) begin miscompares++; $display("FAIL lane1_back_in_run: got rv=%b pc=%h fl=%b want 1/00000500/0", redirect_valid, redirect_pc, ext_flush); end
    endtask

    task automatic test_both_lanes();
        apply_reset();
        br_valid = 2'b11; br_mispredict = 2'b11;
        br_target[0] = 32'h100; br_target[1] = 32'h200;
        tick();
        clear_inputs();
        vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin miscompares++; $display("FAIL both_pc: got rv=%b pc=%h want 1/00000100", redirect_valid, redirect_pc); end
        vectors++; if (mispredict_cnt !== 4'd1) begin miscompares++; $display("FAIL both_mpcnt: got %0d want 1", mispredict_cnt); end
        dec_redirect_valid = 1'b1; dec_redirect_target = 32'h700;
        tick();
        clear_inputs();
        vectors++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h100) begin miscompares++; $display("FAIL both_dec_in_flush: got rv=%b pc=%h want 0/00000100", redirect_valid, redirect_pc); end
        tick();
        tick();
    endtask

    task automatic test_restart();
        apply_reset();
        br_valid = 2'b01; br_mispredict = 2'b01; br_target[0] = 32'h200;
        tick();
        clear_inputs();
        tick();
        vectors++; if (ext_flush !== 1'b1) begin miscompares++; $display("FAIL restart_flush2: got %b want 1", ext_flush); end
        br_valid = 2'b01; br_mispredict = 2'b01; br_target[0] = 32'h300;
        tick();
        clear_inputs();
        vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin miscompares++; $display("FAIL restart_pulse: got rv=%b pc=%h want 1/00000300", redirect_valid, redirect_pc); end
        vectors++; if (ext_flush !== 1'b1 || mispredict_cnt !== 4'd2) begin miscompares++; $display("FAIL restart_flush_a: got fl=%b cnt=%0d want 1/2", ext_flush, mispredict_cnt); end
        tick();
        vectors++; if (ext_flush !== 1'b1 || redirect_valid !== 1'b0) begin miscompares++; $display("FAIL restart_flush_b: got fl=%b rv=%b want 1/0", ext_flush, redirect_valid); end
        dec_redirect_valid = 1'b1; dec_redirect_target = 32'h900;
        tick();
        vectors++; if (ext_flush !== 1'b0 || redirect_valid !== 1'b0) begin miscompares++; $display("FAIL restart_refill: got fl=%b rv=%b want 0/0", ext_flush, redirect_valid); end
        tick();
        clear_inputs();
        vectors++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h300) begin miscompares++; $display("FAIL restart_dec_in_refill: got rv=%b pc=%h want 0/00000300", redirect_valid, redirect_pc); end
    endtask

    task automatic test_stall();
        apply_reset();
        be_free_slots = 4'd1;
        vectors++; if (ext_stall !== 1'b0) begin miscompares++; $display("FAIL stall_lag: got %b want 0", ext_stall); end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (ext_stall !== 1'b1) begin miscompares++; $display("FAIL stall_on[%0d]: got %b want 1", i, ext_stall); end
        end
        be_free_slots = 4'd8;
        tick();
        vectors++; if (ext_stall !== 1'b0) begin miscompares++; $display("FAIL stall_off: got %b want 0", ext_stall); end
        vectors++; if (stall_cnt !== 4'd5) begin miscompares++; $display("FAIL stall_cnt: got %0d want 5", stall_cnt); end
    endtask

    task automatic test_exe_over_dec();
        apply_reset();
        be_free_slots = 4'd1;
        br_valid = 2'b01; br_mispredict = 2'b01; br_target[0] = 32'h800;
        dec_redirect_valid = 1'b1; dec_redirect_target = 32'h900;
        tick();
        br_valid = 2'b00; br_mispredict = 2'b00; dec_redirect_valid = 1'b0;
        vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h800) begin miscompares++; $display("FAIL exe_wins: got rv=%b pc=%h want 1/00000800", redirect_valid, redirect_pc); end
        vectors++; if (ext_flush !== 1'b1 || ext_stall !== 1'b0) begin miscompares++; $display("FAIL flush_blocks_stall: got fl=%b st=%b want 1/0", ext_flush, ext_stall); end
        tick();
        vectors++; if (redirect_valid !== 1'b0 || ext_stall !== 1'b0) begin miscompares++; $display("FAIL exe_single_pulse: got rv=%b st=%b want 0/0", redirect_valid, ext_stall); end
        tick();
        vectors++; if (ext_flush !== 1'b0 || ext_stall !== 1'b0) begin miscompares++; $display("FAIL refill_no_stall: got fl=%b st=%b want 0/0", ext_flush, ext_stall); end
        tick();
        vectors++; if (ext_stall !== 1'b1) begin miscompares++; $display("FAIL stall_after_refill: got %b want 1", ext_stall); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_flush();
        apply_reset();
        br_valid = 2'b01; br_mispredict = 2'b01; br_target[0] = 32'h440;
        tick();
        clear_inputs();
        vectors++; if (ext_flush !== 1'b1) begin miscompares++; $display("FAIL midrst_pre: got %b want 1", ext_flush); end
        #2;
        reset = 1'b0;
        #1;
        vectors++; if (ext_flush !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin miscompares++; $display("FAIL midrst_async: got fl=%b rv=%b pc=%h want 0/0/0", ext_flush, redirect_valid, redirect_pc); end
        vectors++; if (mispredict_cnt !== 4'd0 || ext_stall !== 1'b0) begin miscompares++; $display("FAIL midrst_cnt: got cnt=%0d st=%b want 0/0", mispredict_cnt, ext_stall); end
        tick();
        reset = 1'b1;
        tick();
        vectors++; if (ext_flush !== 1'b0 || redirect_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_after: got fl=%b rv=%b want 0/0", ext_flush, redirect_valid); end
        dec_redirect_valid = 1'b1; dec_redirect_target = 32'h600;
        tick();
        clear_inputs();
        vectors++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h600) begin miscompares++; $display("FAIL midrst_run: got rv=%b pc=%h want 1/00000600", redirect_valid, redirect_pc); end
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            br_valid = 2'b01; br_mispredict = 2'b01; br_target[0] = 32'h1000 + 32'(i);
            tick();
            if (i == 13) begin
                vectors++; if (mispredict_cnt !== 4'd14) begin miscompares++; $display("FAIL sat_14: got %0d want 14", mispredict_cnt); end
            end
            if (i == 14 || i == 19) begin
                vectors++; if (mispredict_cnt !== 4'd15) begin miscompares++; $display("FAIL sat_15[%0d]: got %0d want 15", i, mispredict_cnt); end
            end
        end
        clear_inputs();
        vectors++; if (redirect_pc !== 32'h1013) begin miscompares++; $display("FAIL sat_last_pc: got %h want 00001013", redirect_pc); end
        tick();
        vectors++; if (mispredict_cnt !== 4'd15) begin miscompares++; $display("FAIL sat_hold: got %0d want 15", mispredict_cnt); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_lane1_mispredict();
        test_both_lanes();
        test_restart();
        test_stall();
        test_exe_over_dec();
        test_reset_mid_flush();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
